seg_capture: RTL and testbench
==============================

# seg_capture

Receive side of the seven-segment display bus. It samples a multiplexed active-low display interface (a_to_g, an, dp), which is the same bus our counter/display drivers produce. It decodes each digit's segment pattern back to a hex nibble once the pattern has been stable long enough, and holds the recovered 8-digit value with per-digit validity and decimal-point flags. It sits in test harnesses and loopback checks downstream of any display driver, giving a machine-readable view of what the display shows.

## Interface
- STABLE_CYCLES, 4, consecutive identical samples required before a digit is committed; legal range 2..255.
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high; priority over every other input.
- a_to_g  in  7  segment pattern, active-low, bit6=a … bit0=g.
- an  in  8  anode selects, active-low; bit k selects digit k.
- dp  in  1  decimal point, active-low.
- clear  in  1  synchronous clear of captured state, same effect as rst on outputs.
- value  out  32  recovered hex; digit k in value[4k+3:4k].
- digit_valid  out  8  bit k = digit k holds a legally decoded pattern.
- dp_bits  out  8  bit k = decimal point of digit k was lit (dp=0) at commit.
- update  out  1  one-cycle pulse on every commit, legal or illegal.
- bad_pattern  out  1  one-cycle pulse when a committed pattern is not in the decode set.
- bad_anode  out  1  one-cycle pulse on an illegal anode vector.

## Operation
- Decode set (a_to_g → nibble): 0000001→0, 1001111→1, 0010010→2, 0000110→3, 1001100→4, 0100100→5, 0100000→6, 0001111→7, 0000000→8, 0000100→9, 0001000→A, 1100000→B, 0110001→C, 1000010→D, 0110000→E, 0111000→F. Any other pattern is illegal.
- Anode classes:
  - exactly one bit low → single digit k;
  - 8'h00 → broadcast, all 8 digits;
  - 8'hFF → idle;
  - any other vector → bad.
- Input tuple {an, a_to_g, dp} is registered every cycle. A run counter tracks consecutive identical samples and restarts at 1 whenever the tuple changes. It saturates; it does not wrap.
- Commit fires exactly once per run, when the run reaches STABLE_CYCLES. A tuple held indefinitely produces one commit. A new commit requires a tuple change.
- Commit for a single digit or broadcast, legal pattern: write the nibble to each target digit, set digit_valid, set dp_bits = ~dp, and pulse update.
- Commit, illegal pattern: for each target digit, clear digit_valid (value nibble unchanged), record dp_bits, and pulse update and bad_pattern.
- Idle runs never commit.
- Bad anode: bad_anode pulses once when the run reaches STABLE_CYCLES. There is no write and no update pulse.
- Untargeted digits keep their value, valid and dp state.

## Timing
- Reset/clear values: value=0, digit_valid=0, dp_bits=0, update=0, bad_pattern=0, bad_anode=0. The sample register resets to idle (an=8'hFF, a_to_g=7'h7F, dp=1) and the run counter to 0.
- Tuple first sampled at edge E0 and held: the commit is visible after edge E0+STABLE_CYCLES. update, bad_pattern and bad_anode are high for exactly that one cycle.
- A tuple change before E0+STABLE_CYCLES−1 aborts the run with no side effects.
- rst or clear mid-run discards the run. The first sample after release counts as run length 1.
- rst and clear together: rst behaviour (identical outputs).
- A change at the commit edge itself: the commit completes and the new tuple starts run length 1.
- Outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset: assert rst 2 cycles with random inputs → all outputs 0; no pulses for STABLE_CYCLES+2 cycles after release with an=8'hFF.
- Broadcast: an=8'h00, a_to_g=0100100, dp=1 held 4 cycles (STABLE_CYCLES=4) → value=32'h55555555, digit_valid=8'hFF, dp_bits=0, single update pulse at E0+4.
- Scanned digits: digit 3 = 0001000 with dp=0, then digit 0 = 0110001 with dp=1, each held 6 cycles → value[15:12]=A, value[3:0]=C, digit_valid=8'h09, dp_bits=8'h08, exactly two update pulses.
- Glitch rejection: the digit-3 pattern held only 3 cycles, then changed → no update, outputs unchanged.
- Illegal inputs:
  - a_to_g=7'h7F on digit 0 held 4 cycles → bad_pattern and update pulse, digit_valid[0]=0, value[3:0] unchanged;
  - an=8'b11110011 held 4 cycles → bad_anode pulse only.
- Long hold and clear: tuple held 20 cycles → exactly one update pulse. Then clear for 1 cycle → all captured outputs 0. The same tuple held 4 more cycles → a recommit occurs.

Source files
------------

// File: rtl/seg_capture.sv
// Receive side of the multiplexed seven-segment bus: recovers per-digit hex
// nibbles, validity and decimal points once a bus tuple has been stable long enough.
module seg_capture #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  i_a_to_g,
  input  logic [7:0]  i_an,
  input  logic        i_dp,
  input  logic        i_clear,
  output logic [31:0] o_value,
  output logic [7:0]  o_digit_valid,
  output logic [7:0]  o_dp_bits,
  output logic        o_update,
  output logic        o_bad_pattern,
  output logic        o_bad_anode
);

  localparam logic [15:0] IDLE_TUPLE = {8'hFF, 7'h7F, 1'b1};
  // Counter saturates one past the commit point so a held tuple commits once.
  localparam logic [8:0] RUN_HIT = 9'(STABLE_CYCLES);
  localparam logic [8:0] RUN_SAT = 9'(STABLE_CYCLES + 1);

  logic [15:0] r_sample;
  logic [8:0]  r_run;
  logic        r_update;
  logic        r_bad_pattern;
  logic        r_bad_anode;

  logic [15:0] w_tuple;
  logic [8:0]  w_run_next;
  logic [7:0]  w_an_n;
  logic [6:0]  w_seg;
  logic        w_dp;
  logic        w_single;
  logic        w_bcast;
  logic        w_idle;
  logic        w_bad_an;
  logic        w_commit;
  logic        w_write;
  logic [7:0]  w_target;
  logic [4:0]  w_dec;
  logic        w_legal;
  logic [3:0]  w_nibble;
  logic        w_reset;

  function automatic logic [4:0] decode(input logic [6:0] seg);
    logic [4:0] res;
    res = 5'b0_0000;
    case (seg)
      7'b0000001: res = 5'h10;
      7'b1001111: res = 5'h11;
      7'b0010010: res = 5'h12;
      7'b0000110: res = 5'h13;
      7'b1001100: res = 5'h14;
      7'b0100100: res = 5'h15;
      7'b0100000: res = 5'h16;
      7'b0001111: res = 5'h17;
      7'b0000000: res = 5'h18;
      7'b0000100: res = 5'h19;
      7'b0001000: res = 5'h1A;
      7'b1100000: res = 5'h1B;
      7'b0110001: res = 5'h1C;
      7'b1000010: res = 5'h1D;
      7'b0110000: res = 5'h1E;
      7'b0111000: res = 5'h1F;
      default:    res = 5'h00;
    endcase
    return res;
  endfunction

  assign w_reset    = rst || i_clear;
  assign w_tuple    = {i_an, i_a_to_g, i_dp};
  assign w_run_next = (w_tuple != r_sample) ? 9'd1 :
                      (r_run >= RUN_SAT)    ? RUN_SAT : r_run + 9'd1;

  // Classification and commit act on the registered sample, not the live bus.
  assign w_an_n   = ~r_sample[15:8];
  assign w_seg    = r_sample[7:1];
  assign w_dp     = r_sample[0];
  assign w_single = (w_an_n != 8'h00) && ((w_an_n & (w_an_n - 8'd1)) == 8'h00);
  assign w_bcast  = (w_an_n == 8'hFF);
  assign w_idle   = (w_an_n == 8'h00);
  assign w_bad_an = !(w_single || w_bcast || w_idle);
  assign w_commit = (r_run == RUN_HIT);
  assign w_write  = w_commit && (w_single || w_bcast);
  assign w_target = w_single ? w_an_n : (w_bcast ? 8'hFF : 8'h00);
  assign w_dec    = decode(w_seg);
  assign w_legal  = w_dec[4];
  assign w_nibble = w_dec[3:0];

  always_ff @(posedge clk) begin
    if (w_reset) begin
      r_sample      <= IDLE_TUPLE;
      r_run         <= 9'd0;
      r_update      <= 1'b0;
      r_bad_pattern <= 1'b0;
      r_bad_anode   <= 1'b0;
    end else begin
      r_sample      <= w_tuple;
      r_run         <= w_run_next;
      r_update      <= w_write;
      r_bad_pattern <= w_write && !w_legal;
      r_bad_anode   <= w_commit && w_bad_an;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_digit
      logic [3:0] r_nib;
      logic       r_vld;
      logic       r_dpb;

      // An illegal pattern invalidates the digit but leaves its last nibble.
      always_ff @(posedge clk) begin
        if (w_reset) begin
          r_nib <= 4'h0;
          r_vld <= 1'b0;
          r_dpb <= 1'b0;
        end else if (w_write && w_target[gi]) begin
          if (w_legal) begin
            r_nib <= w_nibble;
          end
          r_vld <= w_legal;
          r_dpb <= ~w_dp;
        end
      end

      assign o_value[4*gi +: 4] = r_nib;
      assign o_digit_valid[gi]  = r_vld;
      assign o_dp_bits[gi]      = r_dpb;
    end
  endgenerate

  assign o_update      = r_update;
  assign o_bad_pattern = r_bad_pattern;
  assign o_bad_anode   = r_bad_anode;

endmodule

// File: tb/tb_seg_capture.sv
// Directed bench for seg_capture: drives bus tuples and compares captured
// state and pulse counts against hand-computed values.
module tb_seg_capture;

  localparam int S = 4;

  logic        clk;
  logic        rst;
  logic [6:0]  a_to_g;
  logic [7:0]  an;
  logic        dp;
  logic        clear;
  logic [31:0] value;
  logic [7:0]  digit_valid;
  logic [7:0]  dp_bits;
  logic        update;
  logic        bad_pattern;
  logic        bad_anode;

  int n_cmp;
  int n_bad;
  int n_upd;
  int n_bpat;
  int n_banode;

  seg_capture #(.STABLE_CYCLES(S)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_a_to_g     (a_to_g),
    .i_an         (an),
    .i_dp         (dp),
    .i_clear      (clear),
    .o_value      (value),
    .o_digit_valid(digit_valid),
    .o_dp_bits    (dp_bits),
    .o_update     (update),
    .o_bad_pattern(bad_pattern),
    .o_bad_anode  (bad_anode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Advance n edges, sampling pulses 1 time unit after each edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (update)      n_upd++;
      if (bad_pattern) n_bpat++;
      if (bad_anode)   n_banode++;
    end
  endtask

  task automatic clr_cnt();
    n_upd = 0;
    n_bpat = 0;
    n_banode = 0;
  endtask

  task automatic drive(input logic [7:0] a, input logic [6:0] s, input logic d);
    an = a;
    a_to_g = s;
    dp = d;
  endtask

  task automatic idle();
    drive(8'hFF, 7'h7F, 1'b1);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    clr_cnt();
    clear = 1'b0;
    rst = 1'b1;
    drive(8'($urandom), 7'($urandom), 1'($urandom));

    // Reset with random bus activity
    step(1);
    drive(8'($urandom), 7'($urandom), 1'($urandom));
    step(1);
    check("rst_value", value, 32'h0);
    check("rst_valid", {24'h0, digit_valid}, 32'h0);
    check("rst_dp", {24'h0, dp_bits}, 32'h0);
    check("rst_pulses", {29'h0, update, bad_pattern, bad_anode}, 32'h0);

    rst = 1'b0;
    drive(8'hFF, 7'($urandom), 1'($urandom));
    clr_cnt();
    step(S + 2);
    check("idle_pulses", 32'(n_upd + n_bpat + n_banode), 32'd0);

    // Broadcast of digit 5 pattern, commit visible after E0+S
    drive(8'h00, 7'b0100100, 1'b1);
    clr_cnt();
    step(S);
    check("bcast_early_upd", 32'(n_upd), 32'd0);
    step(1);
    check("bcast_upd_edge", {31'h0, update}, 32'd1);
    idle();
    step(3);
    check("bcast_upd_count", 32'(n_upd), 32'd1);
    check("bcast_value", value, 32'h5555_5555);
    check("bcast_valid", {24'h0, digit_valid}, 32'h0000_00FF);
    check("bcast_dp", {24'h0, dp_bits}, 32'h0);

    // Clear, then scan two digits back to back
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check("clear_value", value, 32'h0);
    clr_cnt();
    drive(8'b1111_0111, 7'b0001000, 1'b0);
    step(6);
    drive(8'b1111_1110, 7'b0110001, 1'b1);
    step(6);
    idle();
    step(S + 2);
    check("scan_upd_count", 32'(n_upd), 32'd2);
    check("scan_value", value, 32'h0000_A00C);
    check("scan_valid", {24'h0, digit_valid}, 32'h0000_0009);
    check("scan_dp", {24'h0, dp_bits}, 32'h0000_0008);

    // Glitch: held one sample short of a commit
    clr_cnt();
    drive(8'b1111_0111, 7'b0001111, 1'b1);
    step(S - 1);
    idle();
    step(S + 2);
    check("glitch_upd", 32'(n_upd), 32'd0);
    check("glitch_value", value, 32'h0000_A00C);

    // Illegal pattern on digit 0 with dp lit
    clr_cnt();
    drive(8'b1111_1110, 7'h7F, 1'b0);
    step(6);
    idle();
    step(2);
    check("badpat_upd", 32'(n_upd), 32'd1);
    check("badpat_pulse", 32'(n_bpat), 32'd1);
    check("badpat_valid", {24'h0, digit_valid}, 32'h0000_0008);
    check("badpat_value", value, 32'h0000_A00C);
    check("badpat_dp", {24'h0, dp_bits}, 32'h0000_0009);

    // Illegal anode vector
    clr_cnt();
    drive(8'b1111_0011, 7'b0000001, 1'b1);
    step(6);
    idle();
    step(2);
    check("badan_pulse", 32'(n_banode), 32'd1);
    check("badan_upd", 32'(n_upd + n_bpat), 32'd0);
    check("badan_value", value, 32'h0000_A00C);

    // Long hold on digit 5, clear, then recommit of the same tuple
    clr_cnt();
    drive(8'b1101_1111, 7'b1001111, 1'b1);
    step(20);
    check("hold_upd_count", 32'(n_upd), 32'd1);
    check("hold_value", value, 32'h0010_A00C);
    check("hold_valid", {24'h0, digit_valid}, 32'h0000_0028);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check("hclr_value", value, 32'h0);
    check("hclr_valid", {24'h0, digit_valid}, 32'h0);
    check("hclr_dp", {24'h0, dp_bits}, 32'h0);
    clr_cnt();
    step(S);
    check("recommit_early", 32'(n_upd), 32'd0);
    step(1);
    check("recommit_edge", {31'h0, update}, 32'd1);
    check("recommit_value", value, 32'h0010_0000);
    check("recommit_valid", {24'h0, digit_valid}, 32'h0000_0020);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
